// File: rtl/dispatch_queue_nway_if.sv
// Decode-to-dispatch bundle for dispatch_queue_nway: enqueue lanes, FU/ROB
// back-pressure and the per-slot dispatch outputs.
interface dispatch_queue_nway_if #(
  parameter int unsigned IN_WIDTH  = 2,
  parameter int unsigned OUT_WIDTH = 2,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned NUM_FU    = 5,
  parameter int unsigned ENTRY_W   = 64
);
  localparam int unsigned CW = $clog2(OUT_WIDTH + 1);
  localparam int unsigned QW = $clog2(DEPTH + 1);

  logic                          flush;
  logic                          stall;
  logic [IN_WIDTH-1:0]           in_valid;
  logic [IN_WIDTH*ENTRY_W-1:0]   in_entry;
  logic [IN_WIDTH*NUM_FU-1:0]    in_fu;
  logic [IN_WIDTH-1:0]           in_ex;
  logic [IN_WIDTH-1:0]           in_branch;
  logic                          in_ready;
  logic [NUM_FU-1:0]             fu_ready;
  logic [CW-1:0]                 rob_credit;
  logic [OUT_WIDTH-1:0]          disp_valid;
  logic [OUT_WIDTH*ENTRY_W-1:0]  disp_entry;
  logic [OUT_WIDTH-1:0]          disp_ex;
  logic [OUT_WIDTH-1:0]          disp_delayslot;
  logic [NUM_FU-1:0]             fu_taken;
  logic [QW-1:0]                 count;

  modport master (
    output flush, stall, in_valid, in_entry, in_fu, in_ex, in_branch,
           fu_ready, rob_credit,
    input  in_ready, disp_valid, disp_entry, disp_ex, disp_delayslot,
           fu_taken, count
  );

  modport slave (
    input  flush, stall, in_valid, in_entry, in_fu, in_ex, in_branch,
           fu_ready, rob_credit,
    output in_ready, disp_valid, disp_entry, disp_ex, disp_delayslot,
           fu_taken, count
  );
endinterface

// File: rtl/dispatch_queue_nway.sv
// In-order circular dispatch queue: multi-lane enqueue, up to OUT_WIDTH in-order
// dispatches per cycle with FU arbitration, ROB credit limit and branch/delay-slot pairing.
module dispatch_queue_nway #(
  parameter int unsigned IN_WIDTH  = 2,
  parameter int unsigned OUT_WIDTH = 2,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned NUM_FU    = 5,
  parameter int unsigned ENTRY_W   = 64
) (
  input logic                   clk,
  input logic                   rst_n,
  dispatch_queue_nway_if.slave  dq
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned QW = $clog2(DEPTH + 1);
  localparam int unsigned CW = $clog2(OUT_WIDTH + 1);

  logic [ENTRY_W-1:0] r_entry [DEPTH];
  logic [NUM_FU-1:0]  r_fu    [DEPTH];
  logic [DEPTH-1:0]   r_ex;
  logic [DEPTH-1:0]   r_br;
  logic [DEPTH-1:0]   r_ds;
  logic [PW-1:0]      r_head;
  logic [PW-1:0]      r_tail;
  logic [QW-1:0]      r_count;
  logic               r_prev_br;

  logic [PW-1:0]      w_slot [OUT_WIDTH];
  logic [OUT_WIDTH-1:0] w_pre;
  logic [OUT_WIDTH:0]   w_ext;
  logic [OUT_WIDTH-1:0] w_go;
  logic [NUM_FU-1:0]  w_used;
  logic               w_open;
  logic               w_in_ready;
  logic               w_enq;
  logic [QW-1:0]      w_nenq;
  logic [CW-1:0]      w_ndeq;
  logic [IN_WIDTH-1:0] w_lane_ds;
  logic               w_last_br;
  logic               w_run_br;
  int                 w_count_nxt;
  logic [NUM_FU-1:0]  w_ft;

  assign w_in_ready = (r_count <= QW'(DEPTH - IN_WIDTH));
  assign w_enq      = w_in_ready && dq.in_valid[0] && !dq.flush;

  // In-order candidate prefix, then trim any trailing branch that lost its delay slot
  always_comb begin
    w_pre  = '0;
    w_used = '0;
    w_open = !(dq.flush || dq.stall);
    for (int k = 0; k < int'(OUT_WIDTH); k++) begin
      w_slot[k] = r_head + PW'(k);
      if (w_open && (k < int'(r_count)) && (k < int'(dq.rob_credit)) &&
          (r_ex[w_slot[k]] ||
           (((dq.fu_ready & r_fu[w_slot[k]]) != '0) && ((w_used & r_fu[w_slot[k]]) == '0)))) begin
        w_pre[k] = 1'b1;
        if (!r_ex[w_slot[k]]) w_used = w_used | r_fu[w_slot[k]];
      end else begin
        w_open = 1'b0;
      end
    end
    w_ext = {1'b0, w_pre};
    for (int k = int'(OUT_WIDTH) - 1; k >= 0; k--) begin
      if (w_ext[k] && r_br[w_slot[k]] && !r_ex[w_slot[k]] && !w_ext[k+1]) w_ext[k] = 1'b0;
    end
    w_go = w_ext[OUT_WIDTH-1:0];
  end

  // Enqueue/dequeue bookkeeping and delay-slot tags per lane
  always_comb begin
    w_nenq    = '0;
    w_ndeq    = '0;
    w_lane_ds = '0;
    w_last_br = r_prev_br;
    w_run_br  = r_prev_br;
    for (int i = 0; i < int'(IN_WIDTH); i++) begin
      w_lane_ds[i] = w_run_br;
      w_run_br     = dq.in_branch[i];
      if (w_enq && dq.in_valid[i]) begin
        w_nenq    = w_nenq + QW'(1);
        w_last_br = dq.in_branch[i];
      end
    end
    for (int k = 0; k < int'(OUT_WIDTH); k++) begin
      w_ndeq = w_ndeq + CW'(w_go[k]);
    end
    w_count_nxt = int'(r_count) + int'(w_nenq) - int'(w_ndeq);
  end

  always_comb begin
    dq.disp_entry     = '0;
    dq.disp_ex        = '0;
    dq.disp_delayslot = '0;
    w_ft              = '0;
    for (int k = 0; k < int'(OUT_WIDTH); k++) begin
      if (w_go[k]) begin
        dq.disp_entry[k*ENTRY_W +: ENTRY_W] = r_entry[w_slot[k]];
        dq.disp_ex[k]        = r_ex[w_slot[k]];
        dq.disp_delayslot[k] = r_ds[w_slot[k]];
        if (!r_ex[w_slot[k]]) w_ft = w_ft | r_fu[w_slot[k]];
      end
    end
  end

  assign dq.disp_valid = w_go;
  assign dq.fu_taken   = w_ft;
  assign dq.in_ready   = w_in_ready;
  assign dq.count      = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n || dq.flush) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_prev_br <= 1'b0;
    end else begin
      assert (w_count_nxt >= 0 && w_count_nxt <= int'(DEPTH));
      r_head  <= r_head + PW'(w_ndeq);
      r_count <= QW'(w_count_nxt);
      if (w_enq) begin
        r_tail    <= r_tail + PW'(w_nenq);
        r_prev_br <= w_last_br;
      end
    end
  end

  // Payload storage needs no reset; head/count gate every read
  always_ff @(posedge clk) begin
    if (w_enq) begin
      for (int i = 0; i < int'(IN_WIDTH); i++) begin
        if (dq.in_valid[i]) begin
          r_entry[r_tail + PW'(i)] <= dq.in_entry[i*ENTRY_W +: ENTRY_W];
          r_fu[r_tail + PW'(i)]    <= dq.in_fu[i*NUM_FU +: NUM_FU];
          r_ex[r_tail + PW'(i)]    <= dq.in_ex[i];
          r_br[r_tail + PW'(i)]    <= dq.in_branch[i];
          r_ds[r_tail + PW'(i)]    <= w_lane_ds[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_dispatch_queue_nway.sv
// Bench for dispatch_queue_nway: directed scenarios then random traffic,
// compared each cycle against a queue-based reference model.
module tb_dispatch_queue_nway;
  localparam int unsigned IW = 2, OW = 2, DEPTH = 8, NFU = 5, EW = 64;
  localparam int unsigned CW = $clog2(OW + 1), QW = $clog2(DEPTH + 1);
  localparam logic [NFU-1:0] FU_ALU = 5'b00001, FU_BR = 5'b00010, FU_LSU = 5'b00100;
  localparam logic [NFU-1:0] FU_ALL = 5'b11111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dispatch_queue_nway_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(DEPTH),
                           .NUM_FU(NFU), .ENTRY_W(EW)) dq_if ();
  dispatch_queue_nway #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(DEPTH),
                        .NUM_FU(NFU), .ENTRY_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .dq(dq_if));

  typedef struct {
    logic [EW-1:0]  e;
    logic [NFU-1:0] fu;
    logic           ex;
    logic           br;
    logic           ds;
  } ment_t;

  ment_t mq[$];
  logic  m_prev = 1'b0;
  int    total = 0;
  int    bad = 0;

  logic [OW-1:0]  obs_dv, obs_ex, obs_ds;
  logic [NFU-1:0] obs_ft;
  logic [QW-1:0]  obs_cnt;
  logic           obs_rdy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic lane(input int i, input logic [NFU-1:0] fu, input logic ex, input logic br);
    dq_if.in_entry[i*EW +: EW] = {$urandom, $urandom};
    dq_if.in_fu[i*NFU +: NFU]  = fu;
    dq_if.in_ex[i]             = ex;
    dq_if.in_branch[i]         = br;
  endtask

  // One cycle: predict and compare outputs mid-cycle, then advance the model at the edge
  task automatic step(input string tag);
    int lim, n;
    logic [NFU-1:0] used, eft;
    logic [OW-1:0]  edv, eex, eds;
    logic [EW-1:0]  ee;
    logic           enq;
    ment_t          me;
    @(negedge clk);
    lim = int'(OW);
    if (int'(dq_if.rob_credit) < lim) lim = int'(dq_if.rob_credit);
    if (mq.size() < lim) lim = mq.size();
    n = 0;
    used = '0;
    if (!dq_if.stall && !dq_if.flush) begin
      while (n < lim) begin
        if (!mq[n].ex) begin
          if ((dq_if.fu_ready & mq[n].fu) == '0 || (used & mq[n].fu) != '0) break;
          used |= mq[n].fu;
        end
        n++;
      end
    end
    while (n > 0 && mq[n-1].br && !mq[n-1].ex) n--;
    edv = '0; eex = '0; eds = '0; eft = '0;
    for (int k = 0; k < n; k++) begin
      edv[k] = 1'b1;
      eex[k] = mq[k].ex;
      eds[k] = mq[k].ds;
      if (!mq[k].ex) eft |= mq[k].fu;
    end
    obs_dv  = dq_if.disp_valid;
    obs_ex  = dq_if.disp_ex;
    obs_ds  = dq_if.disp_delayslot;
    obs_ft  = dq_if.fu_taken;
    obs_cnt = dq_if.count;
    obs_rdy = dq_if.in_ready;
    check({tag, ".rdy"}, 64'(obs_rdy), 64'(mq.size() <= int'(DEPTH - IW)));
    check({tag, ".cnt"}, 64'(obs_cnt), 64'(mq.size()));
    check({tag, ".dv"},  64'(obs_dv), 64'(edv));
    check({tag, ".ex"},  64'(obs_ex), 64'(eex));
    check({tag, ".ds"},  64'(obs_ds), 64'(eds));
    check({tag, ".ft"},  64'(obs_ft), 64'(eft));
    for (int k = 0; k < int'(OW); k++) begin
      ee = (k < n) ? mq[k].e : '0;
      check({tag, ".ent"}, dq_if.disp_entry[k*EW +: EW], ee);
    end
    @(posedge clk);
    if (!rst_n || dq_if.flush) begin
      mq.delete();
      m_prev = 1'b0;
    end else begin
      enq = (mq.size() <= int'(DEPTH - IW)) && dq_if.in_valid[0];
      repeat (n) void'(mq.pop_front());
      if (enq) begin
        for (int i = 0; i < int'(IW); i++) begin
          if (dq_if.in_valid[i]) begin
            me.e  = dq_if.in_entry[i*EW +: EW];
            me.fu = dq_if.in_fu[i*NFU +: NFU];
            me.ex = dq_if.in_ex[i];
            me.br = dq_if.in_branch[i];
            me.ds = m_prev;
            m_prev = me.br;
            mq.push_back(me);
          end
        end
      end
    end
    #1;
  endtask

  initial begin
    int sel;
    dq_if.flush = 1'b0; dq_if.stall = 1'b0; dq_if.in_valid = '0;
    dq_if.in_entry = '0; dq_if.in_fu = '0; dq_if.in_ex = '0; dq_if.in_branch = '0;
    dq_if.fu_ready = FU_ALL; dq_if.rob_credit = CW'(2);
    repeat (2) @(posedge clk);
    #1;
    step("rst");
    check("rst_rdy_c", 64'(obs_rdy), 64'd1);
    check("rst_dv_c", 64'(obs_dv), 64'd0);
    rst_n = 1'b1;

    // Two ALU ops: same-FU conflict serialises them
    dq_if.in_valid = 2'b11; lane(0, FU_ALU, 0, 0); lane(1, FU_ALU, 0, 0);
    step("t1_enq");
    dq_if.in_valid = '0;
    step("t1_a");
    check("t1_dv_c", 64'(obs_dv), 64'b01);
    check("t1_ft_c", 64'(obs_ft), 64'(FU_ALU));
    step("t1_b");
    check("t1_dv2_c", 64'(obs_dv), 64'b01);

    // ROB credit of one limits to a single dispatch
    dq_if.rob_credit = CW'(1);
    dq_if.in_valid = 2'b11; lane(0, FU_ALU, 0, 0); lane(1, FU_LSU, 0, 0);
    step("t2_enq");
    dq_if.in_valid = '0;
    step("t2_a");
    check("t2_dv_c", 64'(obs_dv), 64'b01);
    dq_if.rob_credit = CW'(2);
    step("t2_b");
    check("t2_ft_c", 64'(obs_ft), 64'(FU_LSU));
    step("t2_c");
    check("t2_cnt_c", 64'(obs_cnt), 64'd0);

    // Branch waits for its delay slot's FU
    dq_if.in_valid = 2'b01; lane(0, FU_BR, 0, 1);
    step("t3_br");
    lane(0, FU_ALU, 0, 0); dq_if.fu_ready = FU_ALL & ~FU_ALU;
    step("t3_ds");
    dq_if.in_valid = '0;
    step("t3_wait");
    check("t3_wait_dv_c", 64'(obs_dv), 64'd0);
    dq_if.fu_ready = FU_ALL;
    step("t3_go");
    check("t3_dv_c", 64'(obs_dv), 64'b11);
    check("t3_ds_c", 64'(obs_ds), 64'b10);

    // Fill to full under stall, then drain across the pointer wrap
    dq_if.stall = 1'b1; dq_if.in_valid = 2'b11;
    repeat (4) begin
      lane(0, FU_ALU, 0, 0); lane(1, FU_LSU, 0, 0);
      step("t4_fill");
    end
    dq_if.stall = 1'b0;
    lane(0, FU_ALU, 0, 0); lane(1, FU_LSU, 0, 0);
    step("t4_full");
    check("t4_cnt_c", 64'(obs_cnt), 64'd8);
    check("t4_rdy_c", 64'(obs_rdy), 64'd0);
    step("t4_after");
    check("t4_cnt2_c", 64'(obs_cnt), 64'd6);
    dq_if.in_valid = '0;
    repeat (3) step("t4_drain");
    step("t4_empty");
    check("t4_cnt3_c", 64'(obs_cnt), 64'd0);

    // Exception entry needs ROB only
    dq_if.in_valid = 2'b01; lane(0, FU_ALU, 1, 0);
    dq_if.fu_ready = '0; dq_if.rob_credit = CW'(1);
    step("t5_enq");
    dq_if.in_valid = '0;
    step("t5_ex");
    check("t5_dv_c", 64'(obs_dv), 64'd1);
    check("t5_ex_c", 64'(obs_ex), 64'd1);
    check("t5_ft_c", 64'(obs_ft), 64'd0);

    // Flush beats enqueue and clears the pending delay-slot tag
    dq_if.fu_ready = FU_ALL; dq_if.rob_credit = CW'(2); dq_if.stall = 1'b1;
    dq_if.in_valid = 2'b11;
    repeat (2) begin
      lane(0, FU_ALU, 0, 0); lane(1, FU_BR, 0, 1);
      step("t6_fill");
    end
    dq_if.flush = 1'b1; lane(0, FU_ALU, 0, 0); lane(1, FU_LSU, 0, 0);
    step("t6_flush");
    check("t6_flush_dv_c", 64'(obs_dv), 64'd0);
    dq_if.flush = 1'b0; dq_if.stall = 1'b0;
    dq_if.in_valid = 2'b01; lane(0, FU_ALU, 0, 0);
    step("t6_post");
    check("t6_cnt_c", 64'(obs_cnt), 64'd0);
    dq_if.in_valid = '0;
    step("t6_ds");
    check("t6_ds_c", 64'(obs_ds), 64'd0);

    // Reset mid-stream
    dq_if.stall = 1'b1; dq_if.in_valid = 2'b11;
    lane(0, FU_ALU, 0, 0); lane(1, FU_LSU, 0, 0);
    step("rm_fill");
    rst_n = 1'b0;
    step("rm_rst");
    rst_n = 1'b1; dq_if.stall = 1'b0; dq_if.in_valid = '0;
    step("rm_after");
    check("rm_cnt_c", 64'(obs_cnt), 64'd0);
    check("rm_rdy_c", 64'(obs_rdy), 64'd1);
    check("rm_dv_c", 64'(obs_dv), 64'd0);

    // Random traffic
    repeat (600) begin
      dq_if.flush = ($urandom_range(0, 24) == 0);
      dq_if.stall = ($urandom_range(0, 6) == 0);
      sel = $urandom_range(0, 2);
      dq_if.in_valid = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11;
      for (int i = 0; i < int'(IW); i++)
        lane(i, NFU'(1 << $urandom_range(0, NFU - 1)),
             $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
      dq_if.fu_ready = ($urandom_range(0, 2) == 0) ? NFU'($urandom) : FU_ALL;
      dq_if.rob_credit = CW'($urandom_range(0, 2));
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
